// File: rtl/multi_precision_mac8.sv
// multi_precision_mac8 -- registered multi-precision multiply-accumulate slice.
//
// Splits an unsigned 8-bit data word into 1, 2 or 4 lanes (8/4/2-bit), multiplies
// each lane by a signed weight of selectable precision (converted to sign/magnitude)
// and sums the lane products. A standalone signed-to-sign/magnitude lane converter
// shares the same conversion function. All outputs are registered (latency 1).
//
// Optional feature: define MULT_SAT_EN to saturate 'mul' to [-128, 127];
// otherwise 'mul' is the low byte of the signed sum.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   d                 unsigned data word
//   w1..w4            signed weights for lanes 0..3
//   convtypeD/W       data/weight precision: 01=2b, 10=4b, 11=8b, 00=invalid
//   addL_res_o        signed sum of lane products (19 bits)
//   addM_res_o        unsigned sum of lane product magnitudes (15 bits)
//   mul               signed 8-bit result derived from addL_res_o
//   sm_d_in           converter input, lanes of two's-complement values
//   sm_convtype       converter lane precision
//   sm_sign           converter per-lane sign bits
//   sm_d_out          converter per-lane magnitudes
module multi_precision_mac8 (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         d,
   input  logic [7:0]         w1,
   input  logic [7:0]         w2,
   input  logic [7:0]         w3,
   input  logic [7:0]         w4,
   input  logic [1:0]         convtypeD,
   input  logic [1:0]         convtypeW,
   output logic signed [18:0] addL_res_o,
   output logic [14:0]        addM_res_o,
   output logic signed [7:0]  mul,
   input  logic [7:0]         sm_d_in,
   input  logic [1:0]         sm_convtype,
   output logic [3:0]         sm_sign,
   output logic [7:0]         sm_d_out
);

   // Lane k of v at precision ct, zero-extended; lanes beyond 8/P read as 0.
   function automatic logic [7:0] lane_of(input logic [7:0] v, input logic [1:0] ct,
                                          input logic [1:0] k);
      logic [7:0] r;
      r = '0;
      case (ct)
         2'b01: r = {6'b0, v[{k, 1'b0} +: 2]};
         2'b10: if (!k[1]) r = {4'b0, v[{k[0], 2'b00} +: 4]};
         2'b11: if (k == 2'd0) r = v;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Bit offset of lane k inside a packed lane vector.
   function automatic logic [2:0] lane_shift(input logic [1:0] ct, input logic [1:0] k);
      logic [2:0] s;
      s = '0;
      case (ct)
         2'b01:   s = {k, 1'b0};
         2'b10:   s = {k[0], 2'b00};
         default: s = '0;
      endcase
      return s;
   endfunction

   // {sign, magnitude} of the low P bits of v read as two's complement.
   // The most negative value maps to magnitude 2^(P-1), which still fits in P bits.
   function automatic logic [8:0] to_sm(input logic [7:0] v, input logic [1:0] ct);
      logic       sgn;
      logic [7:0] mag;
      sgn = 1'b0;
      mag = '0;
      case (ct)
         2'b01: begin
            sgn = v[1];
            mag = {6'b0, sgn ? 2'(2'd0 - v[1:0]) : v[1:0]};
         end
         2'b10: begin
            sgn = v[3];
            mag = {4'b0, sgn ? 4'(4'd0 - v[3:0]) : v[3:0]};
         end
         2'b11: begin
            sgn = v[7];
            mag = sgn ? 8'(8'd0 - v) : v;
         end
         default: begin
            sgn = 1'b0;
            mag = '0;
         end
      endcase
      return {sgn, mag};
   endfunction

   logic [7:0]         w_arr [4];
   logic [7:0]         lane_d;
   logic [8:0]         w_sm;
   logic [15:0]        prod;
   logic signed [18:0] sum_l_d;
   logic [14:0]        sum_m_d;
   logic signed [7:0]  mul_d;
   logic [8:0]         sm_lane;
   logic [3:0]         sm_sign_d;
   logic [7:0]         sm_out_d;

   assign w_arr[0] = w1;
   assign w_arr[1] = w2;
   assign w_arr[2] = w3;
   assign w_arr[3] = w4;

   // Invalid precision needs no explicit gating: lane_of/to_sm return 0 for 00,
   // so every product, and therefore both sums, collapse to 0.
   always_comb begin
      sum_l_d = '0;
      sum_m_d = '0;
      lane_d  = '0;
      w_sm    = '0;
      prod    = '0;
      for (int k = 0; k < 4; k++) begin
         lane_d  = lane_of(d, convtypeD, 2'(k));
         w_sm    = to_sm(w_arr[k], convtypeW);
         prod    = 16'(lane_d) * 16'(w_sm[7:0]);
         sum_m_d = 15'(16'(sum_m_d) + prod);
         if (w_sm[8]) sum_l_d = sum_l_d - signed'({3'b0, prod});
         else         sum_l_d = sum_l_d + signed'({3'b0, prod});
      end
   end

   always_comb begin
      mul_d = sum_l_d[7:0];
`ifdef MULT_SAT_EN
      if (sum_l_d > 19'sd127) begin
         mul_d = 8'sh7f;
      end else if (sum_l_d < -19'sd128) begin
         mul_d = 8'sh80;
      end
`endif
   end

   always_comb begin
      sm_sign_d = '0;
      sm_out_d  = '0;
      sm_lane   = '0;
      for (int k = 0; k < 4; k++) begin
         sm_lane      = to_sm(lane_of(sm_d_in, sm_convtype, 2'(k)), sm_convtype);
         sm_sign_d[k] = sm_lane[8];
         sm_out_d     = sm_out_d | (sm_lane[7:0] << lane_shift(sm_convtype, 2'(k)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addL_res_o <= '0;
         addM_res_o <= '0;
         mul        <= '0;
         sm_sign    <= '0;
         sm_d_out   <= '0;
      end else begin
         addL_res_o <= sum_l_d;
         addM_res_o <= sum_m_d;
         mul        <= mul_d;
         sm_sign    <= sm_sign_d;
         sm_d_out   <= sm_out_d;
      end
   end

endmodule

// File: tb/tb_multi_precision_mac8.sv
// Self-checking bench for multi_precision_mac8: directed test-plan cases, reset and
// invalid-mode cases, randomized MAC traffic and a full converter sweep, all checked
// against an arithmetic reference model.
module tb_multi_precision_mac8;

   logic               clk = 1'b0;
   logic               rst;
   logic [7:0]         d, w1, w2, w3, w4;
   logic [1:0]         convtypeD, convtypeW;
   logic signed [18:0] addL_res_o;
   logic [14:0]        addM_res_o;
   logic signed [7:0]  mul;
   logic [7:0]         sm_d_in;
   logic [1:0]         sm_convtype;
   logic [3:0]         sm_sign;
   logic [7:0]         sm_d_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_precision_mac8 dut (
      .clk        (clk),
      .rst        (rst),
      .d          (d),
      .w1         (w1),
      .w2         (w2),
      .w3         (w3),
      .w4         (w4),
      .convtypeD  (convtypeD),
      .convtypeW  (convtypeW),
      .addL_res_o (addL_res_o),
      .addM_res_o (addM_res_o),
      .mul        (mul),
      .sm_d_in    (sm_d_in),
      .sm_convtype(sm_convtype),
      .sm_sign    (sm_sign),
      .sm_d_out   (sm_d_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int prec(input logic [1:0] ct);
      case (ct)
         2'b01:   return 2;
         2'b10:   return 4;
         2'b11:   return 8;
         default: return 0;
      endcase
   endfunction

   // Reference MAC: plain integer arithmetic over the active lanes.
   function automatic void model_mac(input logic [7:0] dd, input logic [7:0] a,
                                     input logic [7:0] b, input logic [7:0] c,
                                     input logic [7:0] e, input logic [1:0] ctd,
                                     input logic [1:0] ctw, output int sl, output int sm,
                                     output int mv);
      int pd, pw, dk, wk;
      int wt[4];
      wt[0] = int'(a); wt[1] = int'(b); wt[2] = int'(c); wt[3] = int'(e);
      pd = prec(ctd);
      pw = prec(ctw);
      sl = 0;
      sm = 0;
      if (pd != 0 && pw != 0) begin
         for (int k = 0; k < 8 / pd; k++) begin
            dk = (int'(dd) >> (k * pd)) % (1 << pd);
            wk = wt[k] % (1 << pw);
            if (wk >= (1 << (pw - 1))) wk = wk - (1 << pw);
            sl += dk * wk;
            sm += dk * (wk < 0 ? -wk : wk);
         end
      end
`ifdef MULT_SAT_EN
      mv = (sl > 127) ? 127 : (sl < -128) ? -128 : sl;
      mv = mv & 255;
`else
      mv = sl & 255;
`endif
   endfunction

   // Reference converter: lane value as signed integer, sign = negative, magnitude = |v|.
   function automatic void model_sm(input logic [7:0] v, input logic [1:0] ct,
                                    output logic [3:0] s, output logic [7:0] o);
      int p, lv, mag;
      p = prec(ct);
      s = '0;
      o = '0;
      if (p != 0) begin
         for (int k = 0; k < 8 / p; k++) begin
            lv = (int'(v) >> (k * p)) % (1 << p);
            s[k] = (lv >= (1 << (p - 1)));
            mag = s[k] ? (1 << p) - lv : lv;
            o = o | 8'(mag << (k * p));
         end
      end
   endfunction

   // Hold current inputs across one edge and compare all outputs with the model.
   task automatic tick(input string tag);
      int         sl, sm, mv;
      logic [3:0] es;
      logic [7:0] eo;
      model_mac(d, w1, w2, w3, w4, convtypeD, convtypeW, sl, sm, mv);
      model_sm(sm_d_in, sm_convtype, es, eo);
      if (rst) begin
         sl = 0; sm = 0; mv = 0; es = '0; eo = '0;
      end
      @(posedge clk);
      #1;
      check({tag, ".addL"}, {13'b0, addL_res_o}, {13'b0, 19'(sl)});
      check({tag, ".addM"}, {17'b0, addM_res_o}, {17'b0, 15'(sm)});
      check({tag, ".mul"}, {24'b0, mul}, {24'b0, 8'(mv)});
      check({tag, ".sm_sign"}, {28'b0, sm_sign}, {28'b0, es});
      check({tag, ".sm_d_out"}, {24'b0, sm_d_out}, {24'b0, eo});
   endtask

   task automatic set_mac(input logic [7:0] dd, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] e, input logic [1:0] ctd,
                          input logic [1:0] ctw);
      d = dd; w1 = a; w2 = b; w3 = c; w4 = e; convtypeD = ctd; convtypeW = ctw;
   endtask

   initial begin
      rst = 1'b1;
      set_mac(8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 2'b11, 2'b11);
      sm_d_in = 8'hA5;
      sm_convtype = 2'b01;
      #1;
      tick("reset0");
      tick("reset1");
      rst = 1'b0;

      // Test-plan directed cases with literal expectations.
      set_mac(8'hFF, 8'h7F, 8'h00, 8'h00, 8'h00, 2'b11, 2'b11);
      sm_d_in = 8'hF1; sm_convtype = 2'b10;
      tick("d_ff_w7f");
      check("tp1.addL", {13'b0, addL_res_o}, 32'h07E81);
      check("tp1.addM", {17'b0, addM_res_o}, 32'd32385);
`ifdef MULT_SAT_EN
      check("tp1.mul", {24'b0, mul}, 32'h7F);
`else
      check("tp1.mul", {24'b0, mul}, 32'h81);
`endif
      check("conv_f1.sign", {28'b0, sm_sign}, 32'b0010);
      check("conv_f1.out", {24'b0, sm_d_out}, 32'h11);

      set_mac(8'hFF, 8'h80, 8'h12, 8'h34, 8'h56, 2'b11, 2'b11);
      sm_d_in = 8'hB4; sm_convtype = 2'b01;
      tick("d_ff_w80");
      check("tp2.addL", {13'b0, addL_res_o}, 32'h78080);
      check("tp2.addM", {17'b0, addM_res_o}, 32'd32640);
      check("tp2.mul", {24'b0, mul}, 32'h80);
      check("conv_b4.sign", {28'b0, sm_sign}, 32'b1100);
      check("conv_b4.out", {24'b0, sm_d_out}, 32'h94);

      set_mac(8'h3A, 8'h0F, 8'h07, 8'hAA, 8'h55, 2'b10, 2'b10);
      sm_d_in = 8'h80; sm_convtype = 2'b11;
      tick("d_3a_4b");
      check("tp3.addL", {13'b0, addL_res_o}, 32'd11);
      check("tp3.addM", {17'b0, addM_res_o}, 32'd31);
      check("tp3.mul", {24'b0, mul}, 32'h0B);
      check("conv_80.sign", {28'b0, sm_sign}, 32'b0001);
      check("conv_80.out", {24'b0, sm_d_out}, 32'h80);

      set_mac(8'hE4, 8'h01, 8'h03, 8'h02, 8'h01, 2'b01, 2'b01);
      tick("d_e4_2b");
      check("tp4.addL", {13'b0, addL_res_o}, {13'b0, -19'sd2});
      check("tp4.addM", {17'b0, addM_res_o}, 32'd8);

      // Mid-stream reset discards the in-flight result; next edge shows new data.
      set_mac(8'hC3, 8'h85, 8'h7E, 8'h01, 8'hFF, 2'b11, 2'b11);
      tick("pre_rst");
      rst = 1'b1;
      set_mac(8'h77, 8'h81, 8'h02, 8'h03, 8'h04, 2'b10, 2'b11);
      tick("mid_rst");
      rst = 1'b0;
      set_mac(8'h9D, 8'hF3, 8'h6C, 8'h80, 8'h7F, 2'b01, 2'b10);
      tick("post_rst");

      // Invalid precisions force arithmetic outputs to 0.
      set_mac(8'hFF, 8'h80, 8'h80, 8'h80, 8'h80, 2'b00, 2'b11);
      tick("inv_d");
      check("inv_d.addL_zero", {13'b0, addL_res_o}, 32'd0);
      set_mac(8'hFF, 8'h80, 8'h80, 8'h80, 8'h80, 2'b11, 2'b00);
      tick("inv_w");

      // Randomized MAC and converter traffic, including invalid modes.
      for (int i = 0; i < 300; i++) begin
         set_mac(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         sm_d_in = 8'($urandom);
         sm_convtype = 2'($urandom_range(0, 3));
         tick("rand");
      end

      // Full converter sweep per valid precision, MAC inputs kept random.
      for (int ct = 1; ct < 4; ct++) begin
         for (int v = 0; v < 256; v++) begin
            set_mac(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)));
            sm_d_in = 8'(v);
            sm_convtype = 2'(ct);
            tick("sweep");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
